ss_enc_emulator: RTL and testbench
==================================

// Module: ss_enc_emulator
// PURPOSE
//  Responder end of the SSI absolute-encoder link: emulates an encoder so the station's SS Enc pins can feed a UUT.
//  Latches a DSP-written position on the first falling edge of the external SSI clock and shifts it out MSB-first on rising edges.
//  Then holds data low for the monoflop time and returns to idle. Sits under BiDir_Bus_16 beside the SSI master logic.
// PARAMETERS
//  DATA_BITS        24   position word width shifted per frame (2..32)
//  MONOFLOP_CYCLES  750  xclk cycles without a clock edge ending a frame (20 us @ 37.5 MHz)
//  SYNC_STAGES      2    synchronizer flops on ss_clk_in (>=2)
// PORTS
//  xclk          in   1          master clock (DSP external bus clock)
//  reset         in   1          asynchronous, active-low reset
//  enable        in   1          1 = emulator owns the data line
//  gray_en       in   1          1 = transmit Gray code of position, 0 = binary
//  pos_data      in   DATA_BITS  position value from bus register
//  pos_load      in   1          1-cycle strobe: pos_data -> shadow register
//  ss_clk_in     in   1          external SSI clock, asynchronous, idles high
//  ss_do         out  1          SSI data out, idles high
//  ss_dat_dir    out  1          data transceiver direction, 1 = drive
//  ss_clk_dir    out  1          clock transceiver direction, tied 0 (receive)
//  busy          out  1          1 while in SHIFT or MONO
//  frame_done    out  1          1-cycle pulse on normal MONO -> IDLE
//  aborted       out  1          1-cycle pulse on SHIFT timeout
//  frame_count   out  16         completed frames, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset: ss_do=1, ss_dat_dir=0, ss_clk_dir=0, busy=0, frame_done=0, aborted=0, frame_count=0, shadow=0, state=IDLE.
//  ss_dat_dir = enable (registered). ss_do and state logic run regardless of enable.
//  Sync: ss_clk_in passes SYNC_STAGES flops plus one edge-detect flop.
//   An edge is seen SYNC_STAGES+1 cycles after the pin; ss_do changes 1 cycle later.
//  Shadow: updated on pos_load in any state. It is Gray-converted (g = b ^ (b>>1)) when latched into the shift register if gray_en=1.
//  States:
//   IDLE: ss_do=1. Falling edge -> load shift reg from shadow, bit_cnt=0, timer=MONOFLOP_CYCLES, go SHIFT. ss_do stays 1.
//   SHIFT: each rising edge -> ss_do=shreg[MSB], shift left, bit_cnt++, reload timer. Falling edges only reload timer.
//    The rising edge after bit_cnt reaches DATA_BITS -> ss_do=0, reload timer, go MONO.
//    Timer reaching 0 -> ss_do=1, aborted pulse, go IDLE; frame_count unchanged.
//   MONO: ss_do=0. Any clock edge reloads timer; no retransmit.
//    Timer reaching 0 -> ss_do=1, frame_done pulse, frame_count++, go IDLE.
//  Timer: counts down one per xclk; edge and expiry in the same cycle -> edge wins (reload).
//  pos_load during SHIFT/MONO changes the shadow only; the in-flight frame is unaffected.
//  gray_en and pos_data changes mid-frame do not affect the in-flight frame.
//  Falling edge in the same cycle as MONO expiry: expiry is taken; that edge does not start a new frame.
//  Reset asserted mid-frame: all outputs take reset values immediately (ss_do=1). frame_count clears.
// TESTING
//  1 DATA_BITS=8, pos_load 0xA5, gray_en=0, 8 clock pulses, then 9th rising edge
//    -> ss_do bits 1,0,1,0,0,1,0,1; then low; frame_done after MONOFLOP_CYCLES of idle clock; frame_count=1.
//  2 gray_en=1, pos 0x0F (Gray 0x08) -> bits 0,0,0,0,1,0,0,0; pos 0xFF -> Gray 0x80 -> 1 then seven 0s.
//  3 Clock stops after 3 rising edges -> aborted pulse MONOFLOP_CYCLES cycles after last edge; ss_do=1; busy=0; frame_count unchanged.
//  4 pos_load 0x3C after frame start -> frame carries old value; next frame carries 0x3C.
//  5 Clock pulses during MONO every 600 cycles -> MONO persists, ss_do=0; frame_done 750 cycles after the last pulse.
//  6 reset low at bit 4 -> ss_do=1, busy=0, frame_count=0. Next falling edge after release starts a clean frame from bit 0.
//    Preset frame_count to 0xFFFF first -> verify it clears, not wraps.

Source files
------------

// File: rtl/ss_enc_emulator_if.sv
// ss_enc_emulator_if: signal bundle between the bus register block, the SSI pins and the
// SSI encoder emulator.
//   master modport : bus/pin side (drives controls, position, ss_clk_in; reads status)
//   slave modport  : the emulator (ss_enc_emulator)
// Signals:
//   enable, gray_en          control bits from the bus register
//   pos_data, pos_load       position word and its 1-cycle load strobe
//   ss_clk_in                external SSI clock (asynchronous, idles high)
//   ss_do, ss_dat_dir        SSI data out and data transceiver direction (1 = drive)
//   ss_clk_dir               clock transceiver direction (always receive)
//   busy, frame_done,        frame status and event pulses
//   aborted, frame_count
interface ss_enc_emulator_if #(
  parameter int unsigned DATA_BITS = 24
);
  logic                 enable;
  logic                 gray_en;
  logic [DATA_BITS-1:0] pos_data;
  logic                 pos_load;
  logic                 ss_clk_in;
  logic                 ss_do;
  logic                 ss_dat_dir;
  logic                 ss_clk_dir;
  logic                 busy;
  logic                 frame_done;
  logic                 aborted;
  logic [15:0]          frame_count;

  modport master (
    output enable, gray_en, pos_data, pos_load, ss_clk_in,
    input  ss_do, ss_dat_dir, ss_clk_dir, busy, frame_done, aborted, frame_count
  );

  modport slave (
    input  enable, gray_en, pos_data, pos_load, ss_clk_in,
    output ss_do, ss_dat_dir, ss_clk_dir, busy, frame_done, aborted, frame_count
  );
endinterface

// File: rtl/ss_enc_emulator.sv
// ss_enc_emulator: responder end of an SSI absolute-encoder link. Emulates an encoder so the
// station's SS Enc pins can feed a UUT. A DSP-written position is held in a shadow register,
// latched (optionally Gray-coded) on the first falling edge of the external SSI clock and
// shifted out MSB-first on the following rising edges. After the last bit the data line is
// held low until the monoflop time passes without a clock edge, then returns high (idle).
// Ports:
//   xclk   master clock (DSP external bus clock)
//   reset  asynchronous, active-low reset
//   bus    ss_enc_emulator_if slave modport (controls, position, SSI pins, status)
module ss_enc_emulator #(
  parameter int unsigned DATA_BITS       = 24,
  parameter int unsigned MONOFLOP_CYCLES = 750,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input logic              xclk,
  input logic              reset,
  ss_enc_emulator_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);
  localparam int unsigned TmrW = $clog2(MONOFLOP_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_BITS);
  localparam logic [TmrW-1:0] TmrInit = TmrW'(MONOFLOP_CYCLES);
  localparam logic [TmrW-1:0] TmrOne  = TmrW'(1);

  typedef enum logic [1:0] {StIdle, StShift, StMono} state_e;

  // Clock synchronizer and registered edge detection. Reset to the idle-high level so that
  // releasing reset never looks like a falling edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ss_clk_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  // Shadow register is written in any state; frames only see it when they start.
  logic [DATA_BITS-1:0] shadow_q;
  logic [DATA_BITS-1:0] load_word;

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
    end else if (bus.pos_load) begin
      shadow_q <= bus.pos_data;
    end
  end

  always_comb begin
    load_word = shadow_q;
    if (bus.gray_en) begin
      load_word = shadow_q ^ (shadow_q >> 1);
    end
  end

  logic                 dat_dir_q;

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      dat_dir_q <= 1'b0;
    end else begin
      dat_dir_q <= bus.enable;
    end
  end

  state_e               state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [TmrW-1:0]      timer_q;
  logic                 ss_do_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 aborted_q;
  logic [15:0]          frame_count_q;

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      ss_do_q       <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      aborted_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          ss_do_q <= 1'b1;
          if (fall_q) begin
            shreg_q   <= load_word;
            bit_cnt_q <= '0;
            timer_q   <= TmrInit;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (rise_q) begin
            timer_q <= TmrInit;
            if (bit_cnt_q == LastCnt) begin
              ss_do_q <= 1'b0;
              state_q <= StMono;
            end else begin
              ss_do_q   <= shreg_q[DATA_BITS-1];
              shreg_q   <= {shreg_q[DATA_BITS-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end else if (fall_q) begin
            timer_q <= TmrInit;
          end else if (timer_q == TmrOne) begin
            // Master stopped clocking mid-word.
            ss_do_q   <= 1'b1;
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_q - TmrOne;
          end
        end
        StMono: begin
          ss_do_q <= 1'b0;
          // A rising edge keeps the monoflop alive. A falling edge coinciding with expiry is
          // dropped: the frame ends and that edge does not start a new one.
          if (rise_q) begin
            timer_q <= TmrInit;
          end else if (timer_q == TmrOne) begin
            ss_do_q       <= 1'b1;
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end else if (fall_q) begin
            timer_q <= TmrInit;
          end else begin
            timer_q <= timer_q - TmrOne;
          end
        end
        default: begin
          ss_do_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ss_do       = ss_do_q;
  assign bus.ss_dat_dir  = dat_dir_q;
  assign bus.ss_clk_dir  = 1'b0;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.aborted     = aborted_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_ss_enc_emulator.sv
// tb_ss_enc_emulator: self-checking bench for ss_enc_emulator. A frame-level reference model
// (position word + bit index + quiet-cycle count) predicts every output each xclk cycle;
// directed frames additionally pin captured bit patterns, latencies and counts to literals.
module tb_ss_enc_emulator;
  localparam int DB = 8;
  localparam int M  = 750;
  localparam int S  = 2;
  localparam int H  = 10;

  logic xclk  = 1'b0;
  logic reset = 1'b0;
  always #5 xclk = ~xclk;

  ss_enc_emulator_if #(.DATA_BITS(DB)) bus ();

  ss_enc_emulator #(
    .DATA_BITS      (DB),
    .MONOFLOP_CYCLES(M),
    .SYNC_STAGES    (S)
  ) dut (
    .xclk (xclk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [S+2:0]  m_hist;   // pin samples, bit 0 newest
  int            m_phase;  // 0 idle, 1 sending word, 2 monoflop
  logic [DB-1:0] m_word;
  logic [DB-1:0] m_shadow;
  int            m_sent;
  int            m_quiet;  // cycles since last timer reload
  logic          m_do, m_dir, m_busy, m_done, m_abort;
  logic [15:0]   m_count;

  task model_reset();
    m_hist   = '1;
    m_phase  = 0;
    m_word   = '0;
    m_shadow = '0;
    m_sent   = 0;
    m_quiet  = 0;
    m_do     = 1'b1;
    m_dir    = 1'b0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_abort  = 1'b0;
    m_count  = '0;
  endtask

  task model_step();
    logic rise, fall;
    m_hist = {m_hist[S+1:0], bus.ss_clk_in};
    // An edge on the pin acts on the outputs S+2 cycles after it is first sampled.
    rise   = m_hist[S+1] & ~m_hist[S+2];
    fall   = ~m_hist[S+1] & m_hist[S+2];
    m_dir  = bus.enable;
    m_done = 1'b0;
    m_abort = 1'b0;
    case (m_phase)
      0: begin
        m_do = 1'b1;
        if (fall) begin
          m_word  = bus.gray_en ? (m_shadow ^ (m_shadow >> 1)) : m_shadow;
          m_sent  = 0;
          m_quiet = 0;
          m_phase = 1;
        end
      end
      1: begin
        if (rise) begin
          m_quiet = 0;
          if (m_sent == DB) begin
            m_do = 1'b0;
            m_phase = 2;
          end else begin
            m_do = m_word[DB-1-m_sent];
            m_sent++;
          end
        end else if (fall) begin
          m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == M) begin
            m_do = 1'b1;
            m_abort = 1'b1;
            m_phase = 0;
          end
        end
      end
      default: begin
        if (rise) begin
          m_quiet = 0;
        end else if (fall && (m_quiet + 1 < M)) begin
          m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == M) begin
            m_do = 1'b1;
            m_done = 1'b1;
            m_count = m_count + 16'd1;
            m_phase = 0;
          end
        end
      end
    endcase
    if (bus.pos_load) m_shadow = bus.pos_data;
    m_busy = (m_phase != 0);
  endtask

  always @(posedge xclk) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge reset) model_reset();

  always @(negedge xclk) begin
    if (chk_en) begin
      check("cycle", {10'd0, bus.ss_do, bus.ss_dat_dir, bus.ss_clk_dir, bus.busy,
                      bus.frame_done, bus.aborted, bus.frame_count},
                     {10'd0, m_do, m_dir, 1'b0, m_busy, m_done, m_abort, m_count});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge xclk);
    #2;
  endtask

  task automatic load(input logic [DB-1:0] v);
    bus.pos_data = v;
    bus.pos_load = 1'b1;
    cyc(1);
    bus.pos_load = 1'b0;
  endtask

  // One SSI clock period; ss_do is sampled late in the high phase.
  task automatic pulse(input int h, output logic sampled);
    bus.ss_clk_in = 1'b0;
    cyc(h);
    bus.ss_clk_in = 1'b1;
    cyc(h);
    sampled = bus.ss_do;
  endtask

  // mid_at < 0: no load during the frame; otherwise load mid_val after pulse mid_at.
  task automatic frame(input int pulses, input int mid_at, input logic [DB-1:0] mid_val,
                       output logic [31:0] bits);
    logic s;
    bits = '0;
    for (int i = 0; i < pulses; i++) begin
      pulse(H, s);
      bits = {bits[30:0], s};
      if (i == mid_at) load(mid_val);
    end
  endtask

  // Returns cycles until the chosen pulse is seen; equals budget if it never comes.
  task automatic wait_pulse(input bit want_done, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      cyc(1);
      cycles++;
      if (want_done ? bus.frame_done : bus.aborted) break;
    end
  endtask

  logic [31:0] bits;
  int          lat;
  logic        s;

  initial begin
    model_reset();
    bus.enable    = 1'b0;
    bus.gray_en   = 1'b0;
    bus.pos_data  = '0;
    bus.pos_load  = 1'b0;
    bus.ss_clk_in = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    check("reset_outputs", {26'd0, bus.ss_do, bus.ss_dat_dir, bus.ss_clk_dir, bus.busy,
                            bus.frame_done, bus.aborted}, 32'h20);
    check("reset_count", {16'd0, bus.frame_count}, 32'd0);
    reset = 1'b1;
    cyc(2);
    bus.enable = 1'b1;

    // Binary frame: 8 data bits then the 9th rising edge drives low.
    load(8'hA5);
    cyc(5);
    frame(9, -1, '0, bits);
    check("bin_a5_bits", {24'd0, bits[8:1]}, 32'hA5);
    check("bin_a5_mono_low", {31'd0, bits[0]}, 32'd0);
    check("bin_a5_busy_mono", {31'd0, bus.busy}, 32'd1);
    wait_pulse(1'b1, 800, lat);
    check("count_after_1", {16'd0, bus.frame_count}, 32'd1);
    cyc(5);

    // Gray frames.
    bus.gray_en = 1'b1;
    load(8'h0F);
    frame(9, -1, '0, bits);
    check("gray_0f_bits", {24'd0, bits[8:1]}, 32'h08);
    cyc(M + 20);
    load(8'hFF);
    frame(9, -1, '0, bits);
    check("gray_ff_bits", {24'd0, bits[8:1]}, 32'h80);
    cyc(M + 20);
    check("count_after_3", {16'd0, bus.frame_count}, 32'd3);
    bus.gray_en = 1'b0;

    // Clock stops after 3 rising edges.
    frame(3, -1, '0, bits);
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    wait_pulse(1'b0, 800, lat);
    check("abort_latency", H + lat, 32'd754);
    cyc(1);
    check("abort_idle", {30'd0, bus.ss_do, bus.busy}, 32'h2);
    check("abort_count", {16'd0, bus.frame_count}, 32'd3);
    cyc(10);

    // Load during a frame only affects the next frame.
    load(8'h11);
    frame(9, 0, 8'h3C, bits);
    check("midload_old", {24'd0, bits[8:1]}, 32'h11);
    cyc(M + 20);
    frame(9, -1, '0, bits);
    check("midload_new", {24'd0, bits[8:1]}, 32'h3C);
    cyc(M + 20);
    check("count_after_5", {16'd0, bus.frame_count}, 32'd5);

    // Clock pulses every 600 cycles keep the monoflop alive.
    load(8'h5A);
    frame(9, -1, '0, bits);
    for (int i = 0; i < 3; i++) begin
      cyc(600 - 2 * H);
      pulse(H, s);
    end
    check("mono_persist", {30'd0, bus.ss_do, bus.busy}, 32'h1);
    wait_pulse(1'b1, 800, lat);
    check("mono_done_latency", H + lat, 32'd754);
    check("count_after_6", {16'd0, bus.frame_count}, 32'd6);
    cyc(10);

    // Reset in the middle of a frame.
    load(8'h77);
    frame(4, -1, '0, bits);
    reset = 1'b0;
    #1;
    check("midreset_out", {29'd0, bus.ss_do, bus.ss_dat_dir, bus.busy}, 32'h4);
    check("midreset_count", {16'd0, bus.frame_count}, 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    load(8'hC3);
    frame(9, -1, '0, bits);
    check("post_reset_bits", {24'd0, bits[8:1]}, 32'hC3);
    wait_pulse(1'b1, 800, lat);
    check("post_reset_count", {16'd0, bus.frame_count}, 32'd1);
    cyc(10);

    // Randomized traffic checked by the model every cycle.
    for (int f = 0; f < 25; f++) begin
      int np, h, gap, sel;
      bus.enable  = 1'($urandom_range(0, 1));
      bus.gray_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) load(DB'($urandom));
      np = $urandom_range(1, DB + 3);
      h  = $urandom_range(2, 12);
      for (int i = 0; i < np; i++) begin
        bus.ss_clk_in = 1'b0;
        cyc(h);
        if ($urandom_range(0, 3) == 0) load(DB'($urandom));
        bus.gray_en = 1'($urandom_range(0, 1));
        bus.ss_clk_in = 1'b1;
        cyc(h);
      end
      sel = $urandom_range(0, 3);
      if (sel == 0) gap = $urandom_range(100, 700);
      else if (sel == 1) gap = $urandom_range(740, 760);
      else gap = $urandom_range(770, 900);
      cyc(gap);
    end
    cyc(M + 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
